// File: rtl/sent_tx_frame_ctrl_if.sv
// Nibble stream between the SENT frame sequencer (master) and the
// nibble pulse generator (slave).
interface sent_tx_frame_ctrl_if;
  logic [3:0] nibble_data;
  logic [1:0] nibble_type;
  logic       nibble_valid;
  logic       nibble_ready;

  modport master (
    output nibble_data,
    output nibble_type,
    output nibble_valid,
    input  nibble_ready
  );

  modport slave (
    input  nibble_data,
    input  nibble_type,
    input  nibble_valid,
    output nibble_ready
  );
endinterface

// File: rtl/sent_tx_frame_ctrl.sv
// SENT frame sequencer: fetches fast-channel data from the data register, then
// streams sync/status/data/CRC/pause nibbles to the pulse generator.
module sent_tx_frame_ctrl #(
  parameter int unsigned LOAD_TIMEOUT = 32
) (
  input  logic                        clk_tx,
  input  logic                        reset_tx,
  input  logic                        cfg_enable,
  input  logic [2:0]                  cfg_format,
  input  logic [3:0]                  cfg_status,
  input  logic                        cfg_pause_en,
  input  logic [15:0]                 data_f1,
  input  logic [11:0]                 data_f2,
  input  logic                        done,
  output logic [2:0]                  load_bit,
  sent_tx_frame_ctrl_if.master        nib,
  output logic                        frame_done,
  output logic                        load_err,
  output logic                        busy
);

  localparam int unsigned TW = $clog2(LOAD_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SYNC, S_STATUS, S_DATA, S_CRC, S_PAUSE
  } state_t;

  state_t        state_q, state_n;
  logic [2:0]    fmt_q, fmt_n;
  logic [3:0]    stat_q, stat_n;
  logic [23:0]   d_q, d_n;
  logic [23:0]   sh_q, sh_n;
  logic [2:0]    rem_q, rem_n;
  logic [TW-1:0] tmo_q, tmo_n;
  logic [2:0]    load_bit_n;
  logic [3:0]    nib_data_q, nib_data_n;
  logic [1:0]    nib_type_q, nib_type_n;
  logic          nib_valid_q, nib_valid_n;
  logic          frame_done_n, load_err_n, busy_n;
  logic          start, xfer, last, six;
  logic [23:0]   ld_word;

  function automatic logic [23:0] map_word(input logic [2:0]  f,
                                           input logic [15:0] a,
                                           input logic [11:0] b);
    case (f)
      3'b001:  return {a[11:0], b};
      3'b110:  return {a[13:0], b[9:0]};
      3'b111:  return {a, b[7:0]};
      default: return {a[11:0], 12'h000};
    endcase
  endfunction

  // Trailing zero nibble is the augmentation; 3-nibble frames stop after 16 bits.
  function automatic logic [3:0] crc4(input logic [23:0] d, input logic six_nib);
    logic [3:0]  c;
    logic [27:0] s;
    logic        fb;
    c = 4'b0101;
    s = six_nib ? {d, 4'h0} : {d[23:12], 16'h0000};
    for (int unsigned i = 0; i < 28; i++) begin
      if (six_nib || i < 16) begin
        fb = c[3] ^ s[27];
        c  = {c[2:0], 1'b0} ^ (fb ? 4'b1101 : 4'b0000);
      end
      s = {s[26:0], 1'b0};
    end
    return c;
  endfunction

  assign nib.nibble_data  = nib_data_q;
  assign nib.nibble_type  = nib_type_q;
  assign nib.nibble_valid = nib_valid_q;

  assign six     = (fmt_q == 3'b001) || (fmt_q == 3'b110) || (fmt_q == 3'b111);
  assign start   = cfg_enable && (cfg_format != 3'b000);
  assign xfer    = nib_valid_q && nib.nibble_ready;
  assign ld_word = done ? map_word(fmt_q, data_f1, data_f2) : '0;

  always_comb begin
    state_n      = state_q;
    fmt_n        = fmt_q;
    stat_n       = stat_q;
    d_n          = d_q;
    sh_n         = sh_q;
    rem_n        = rem_q;
    tmo_n        = tmo_q;
    load_bit_n   = load_bit;
    nib_data_n   = nib_data_q;
    nib_type_n   = nib_type_q;
    nib_valid_n  = nib_valid_q;
    frame_done_n = 1'b0;
    load_err_n   = load_err;
    last         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_n    = S_LOAD;
          fmt_n      = cfg_format;
          stat_n     = cfg_status;
          load_bit_n = cfg_format;
          tmo_n      = '0;
        end
      end
      S_LOAD: begin
        if (done || (tmo_q == TW'(LOAD_TIMEOUT - 1))) begin
          // ld_word is zero on timeout, so the frame carries zero data.
          if (!done) load_err_n = 1'b1;
          d_n         = ld_word;
          sh_n        = ld_word;
          load_bit_n  = '0;
          state_n     = S_SYNC;
          nib_valid_n = 1'b1;
          nib_type_n  = 2'd0;
          nib_data_n  = '0;
        end else begin
          tmo_n = tmo_q + 1'b1;
        end
      end
      S_SYNC: begin
        if (xfer) begin
          state_n    = S_STATUS;
          nib_type_n = 2'd1;
          nib_data_n = stat_q;
        end
      end
      S_STATUS: begin
        if (xfer) begin
          state_n    = S_DATA;
          nib_data_n = sh_q[23:20];
          sh_n       = {sh_q[19:0], 4'h0};
          rem_n      = six ? 3'd5 : 3'd2;
        end
      end
      S_DATA: begin
        if (xfer) begin
          if (rem_q == 3'd0) begin
            state_n    = S_CRC;
            nib_type_n = 2'd2;
            nib_data_n = crc4(d_q, six);
          end else begin
            nib_data_n = sh_q[23:20];
            sh_n       = {sh_q[19:0], 4'h0};
            rem_n      = rem_q - 3'd1;
          end
        end
      end
      S_CRC: begin
        if (xfer) begin
          if (cfg_pause_en) begin
            state_n    = S_PAUSE;
            nib_type_n = 2'd3;
            nib_data_n = '0;
          end else begin
            last = 1'b1;
          end
        end
      end
      S_PAUSE: begin
        if (xfer) last = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase

    if (last) begin
      frame_done_n = 1'b1;
      nib_valid_n  = 1'b0;
      if (start) begin
        state_n    = S_LOAD;
        fmt_n      = cfg_format;
        stat_n     = cfg_status;
        load_bit_n = cfg_format;
        tmo_n      = '0;
      end else begin
        state_n = S_IDLE;
      end
    end

    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk_tx) begin
    if (reset_tx) begin
      state_q     <= S_IDLE;
      fmt_q       <= '0;
      stat_q      <= '0;
      d_q         <= '0;
      sh_q        <= '0;
      rem_q       <= '0;
      tmo_q       <= '0;
      load_bit    <= '0;
      nib_data_q  <= '0;
      nib_type_q  <= '0;
      nib_valid_q <= 1'b0;
      frame_done  <= 1'b0;
      load_err    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_n;
      fmt_q       <= fmt_n;
      stat_q      <= stat_n;
      d_q         <= d_n;
      sh_q        <= sh_n;
      rem_q       <= rem_n;
      tmo_q       <= tmo_n;
      load_bit    <= load_bit_n;
      nib_data_q  <= nib_data_n;
      nib_type_q  <= nib_type_n;
      nib_valid_q <= nib_valid_n;
      frame_done  <= frame_done_n;
      load_err    <= load_err_n;
      busy        <= busy_n;
    end
  end

endmodule

// File: tb/tb_sent_tx_frame_ctrl.sv
// Bench for sent_tx_frame_ctrl: directed and randomized frames compared slot by
// slot against an arithmetic reference of the SENT frame content.
module tb_sent_tx_frame_ctrl;
  localparam int unsigned TMO = 32;

  logic        clk_tx       = 1'b0;
  logic        reset_tx     = 1'b1;
  logic        cfg_enable   = 1'b0;
  logic [2:0]  cfg_format   = '0;
  logic [3:0]  cfg_status   = '0;
  logic        cfg_pause_en = 1'b0;
  logic [15:0] data_f1      = '0;
  logic [11:0] data_f2      = '0;
  logic        done         = 1'b0;
  logic [2:0]  load_bit;
  logic        frame_done, load_err, busy;

  sent_tx_frame_ctrl_if nib ();

  sent_tx_frame_ctrl #(.LOAD_TIMEOUT(TMO)) dut (
    .clk_tx       (clk_tx),
    .reset_tx     (reset_tx),
    .cfg_enable   (cfg_enable),
    .cfg_format   (cfg_format),
    .cfg_status   (cfg_status),
    .cfg_pause_en (cfg_pause_en),
    .data_f1      (data_f1),
    .data_f2      (data_f2),
    .done         (done),
    .load_bit     (load_bit),
    .nib          (nib),
    .frame_done   (frame_done),
    .load_err     (load_err),
    .busy         (busy)
  );

  always #5 clk_tx = ~clk_tx;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int          obs[$];
  int unsigned lb_run = 0, lb_len = 0;
  logic        fd_prev = 1'b0;
  logic        stalled = 1'b0;
  logic [5:0]  held = '0;
  int          ready_mode = 0;
  int          stall_cnt = 0;
  bit          stall_arm = 1'b0;
  bit          err_exp = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_tx);
    #1;
  endtask

  // Reference model of frame content
  function automatic int ref_count(input int f);
    return (f == 1 || f == 6 || f == 7) ? 6 : 3;
  endfunction

  function automatic int ref_word(input int f, input int a, input int b);
    case (f)
      1:       return (a % 4096) * 4096 + (b % 4096);
      6:       return (a % 16384) * 1024 + (b % 1024);
      7:       return a * 256 + (b % 256);
      default: return (a % 4096) * 4096;
    endcase
  endfunction

  function automatic int ref_crc(input int nibs[$]);
    int c = 5;
    int v, fb;
    for (int k = 0; k <= nibs.size(); k++) begin
      v = (k < nibs.size()) ? nibs[k] : 0;
      for (int b = 3; b >= 0; b--) begin
        fb = ((c / 8) % 2) ^ ((v >> b) % 2);
        c  = ((c * 2) % 16) ^ (fb * 13);
      end
    end
    return c;
  endfunction

  // Transfer monitor, hold-stability and pulse-width checks
  always @(negedge clk_tx) begin
    if (reset_tx) begin
      stalled = 1'b0;
    end else begin
      if (stalled)
        check("hold", {nib.nibble_valid, nib.nibble_type, nib.nibble_data}, {1'b1, held});
      if (nib.nibble_valid && nib.nibble_ready)
        obs.push_back(int'({nib.nibble_type, nib.nibble_data}));
      stalled = nib.nibble_valid && !nib.nibble_ready;
      held    = {nib.nibble_type, nib.nibble_data};
    end
    if (fd_prev) check("frame_done_width", frame_done, 0);
    fd_prev = frame_done;
    if (load_bit != 3'b000) begin
      lb_run++;
    end else begin
      if (lb_run != 0) lb_len = lb_run;
      lb_run = 0;
    end
  end

  // Ready driver: always, random, or a 10-cycle stall on the STATUS slot
  always @(posedge clk_tx) begin
    #2;
    if (stall_cnt > 0) begin
      nib.nibble_ready = 1'b0;
      stall_cnt--;
    end else if (stall_arm && nib.nibble_valid && obs.size() == 1) begin
      stall_arm        = 1'b0;
      stall_cnt        = 9;
      nib.nibble_ready = 1'b0;
    end else begin
      nib.nibble_ready = (ready_mode == 1) ? ($urandom_range(0, 9) < 7) : 1'b1;
    end
  end

  task automatic wait_obs(input int n, input int limit, input string t);
    int cyc = 0;
    while (obs.size() < n && cyc < limit) begin
      tick();
      cyc++;
    end
    if (obs.size() < n) check({t, " wait_slot"}, obs.size(), n);
  endtask

  task automatic run_frame(input int fmt, input int stat, input int a, input int b,
                           input bit pause, input int delay, input int rmode,
                           input bit nen, input int nfmt, input int nstat, input int exp_crc);
    int    exp_q[$];
    int    nibs[$];
    int    w, cyc, n;
    bit    nxt;
    string t;
    t = $sformatf("f%0d", fmt);
    obs.delete();
    cfg_enable   = 1'b1;
    cfg_format   = 3'(fmt);
    cfg_status   = 4'(stat);
    cfg_pause_en = pause;
    data_f1      = 16'(a);
    data_f2      = 12'(b);
    ready_mode   = rmode;
    stall_arm    = (rmode == 2);

    cyc = 0;
    while (load_bit == 3'b000 && cyc < 50) begin
      tick();
      cyc++;
    end
    check({t, " load_bit"}, load_bit, fmt);
    check({t, " busy"}, busy, 1);
    if (delay >= 0) begin
      repeat (delay) tick();
      done = 1'b1;
      tick();
      done = 1'b0;
    end
    wait_obs(1, TMO + 60, t);
    check({t, " load_len"}, lb_len, (delay < 0) ? TMO : delay + 1);
    if (delay < 0) err_exp = 1'b1;
    check({t, " load_err"}, load_err, err_exp);

    wait_obs(2, 300, t);
    cfg_enable = nen;
    cfg_format = 3'(nfmt);
    cfg_status = 4'(nstat);

    cyc = 0;
    while (!frame_done && cyc < 2000) begin
      tick();
      cyc++;
    end
    check({t, " frame_done"}, frame_done, 1);
    check({t, " valid_gap"}, nib.nibble_valid, 0);

    n = ref_count(fmt);
    w = (delay < 0) ? 0 : ref_word(fmt, a, b);
    exp_q.push_back(0);
    exp_q.push_back(16 + stat);
    for (int i = 0; i < n; i++) begin
      nibs.push_back((w >> (20 - 4 * i)) % 16);
      exp_q.push_back(16 + nibs[i]);
    end
    exp_q.push_back(32 + ref_crc(nibs));
    if (pause) exp_q.push_back(48);

    check({t, " slot_count"}, obs.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
      check($sformatf("%s slot%0d", t, i), obs[i], exp_q[i]);
    if (exp_crc >= 0 && obs.size() > n + 2)
      check({t, " crc_const"}, obs[n + 2], 32 + exp_crc);

    nxt = nen && (nfmt != 0);
    check({t, " next_load_bit"}, load_bit, nxt ? nfmt : 0);
    check({t, " next_busy"}, busy, nxt);
  endtask

  initial begin
    int cf, cs, nf, ns, cyc;
    bit ne;

    repeat (3) tick();
    check("rst load_bit", load_bit, 0);
    check("rst valid", nib.nibble_valid, 0);
    check("rst frame_done", frame_done, 0);
    check("rst load_err", load_err, 0);
    check("rst busy", busy, 0);
    reset_tx = 1'b0;

    run_frame(2, 3, 'h000, 'h000, 0, 8, 0, 1, 2, 3, 9);
    run_frame(2, 3, int'($urandom_range(0, 65535)), int'($urandom_range(0, 4095)), 0, 3, 2, 1, 7, 5, -1);
    run_frame(7, 5, 'h1234, 'h056, 0, 2, 1, 1, 6, 9, -1);
    run_frame(6, 9, 'h2ABC, 'h155, 1, 5, 0, 1, 2, 4, -1);
    cf = int'($urandom_range(1, 7));
    cs = int'($urandom_range(0, 15));
    run_frame(2, 4, int'($urandom_range(0, 65535)), int'($urandom_range(0, 4095)), 0, -1, 1, 1, cf, cs, 9);

    for (int k = 0; k < 12; k++) begin
      nf = int'($urandom_range(1, 7));
      ns = int'($urandom_range(0, 15));
      ne = (k == 11) ? 1'b0 : ($urandom_range(0, 3) != 0);
      run_frame(cf, cs, int'($urandom_range(0, 65535)), int'($urandom_range(0, 4095)),
                bit'($urandom_range(0, 1)), int'($urandom_range(0, 10)),
                int'($urandom_range(0, 2)), ne, nf, ns, -1);
      cf = nf;
      cs = ns;
    end

    // Reset in the middle of the DATA slots
    obs.delete();
    ready_mode   = 0;
    cfg_enable   = 1'b1;
    cfg_format   = 3'b001;
    cfg_status   = 4'hA;
    cfg_pause_en = 1'b0;
    cyc = 0;
    while (load_bit == 3'b000 && cyc < 50) begin
      tick();
      cyc++;
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    wait_obs(3, 100, "rst_mid");
    cfg_enable = 1'b0;
    reset_tx   = 1'b1;
    tick();
    check("mid load_bit", load_bit, 0);
    check("mid valid", nib.nibble_valid, 0);
    check("mid data", nib.nibble_data, 0);
    check("mid type", nib.nibble_type, 0);
    check("mid frame_done", frame_done, 0);
    check("mid load_err", load_err, 0);
    check("mid busy", busy, 0);
    reset_tx = 1'b0;
    tick();
    tick();
    check("post busy", busy, 0);
    check("post load_bit", load_bit, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
